// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
// Module   : mem_dma
// Brief    : Word-copy DMA initiator for the picorv32 native memory bus,
//            programmed through a zero-wait-state register port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_dma #(
    parameter int LEN_BITS = 16,
    parameter int ADDR_INC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [3:0]  s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_ready,
    output logic [31:0] s_rdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        irq
);

    localparam logic [1:0] c_reg_src  = 2'd0;
    localparam logic [1:0] c_reg_dst  = 2'd1;
    localparam logic [1:0] c_reg_len  = 2'd2;
    localparam logic [1:0] c_reg_ctrl = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR     = 3'd3,
        S_WR_GAP = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [31:0]         buf_q, buf_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic                irq_en_q, irq_en_d;
    logic                abort_pend_q, abort_pend_d;
    logic                irq_q, irq_d;

    logic                w_busy;
    logic                w_reg_wr;
    logic                w_ctrl_wr;
    logic                w_start;
    logic                w_clear;
    logic                w_abort;
    logic                w_len_zero;
    logic                w_unused;

    always_comb begin
        w_busy     = (state_q != S_IDLE);
        w_reg_wr   = s_valid && (s_wstrb != 4'b0000);
        w_ctrl_wr  = w_reg_wr && (s_addr[3:2] == c_reg_ctrl);
        w_start    = w_ctrl_wr && s_wdata[0] && !w_busy;
        w_clear    = w_ctrl_wr && s_wdata[1];
        w_abort    = w_ctrl_wr && s_wdata[2];
        w_len_zero = (len_q == '0);
        w_unused   = ^s_addr[1:0];
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        buf_d        = buf_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        irq_en_d     = irq_en_q;
        abort_pend_d = abort_pend_q;

        if (w_reg_wr && !w_busy) begin
            case (s_addr[3:2])
                c_reg_src: src_d = {s_wdata[31:2], 2'b00};
                c_reg_dst: dst_d = {s_wdata[31:2], 2'b00};
                c_reg_len: len_d = s_wdata[LEN_BITS-1:0];
                default:   ;
            endcase
        end
        if (w_ctrl_wr) begin
            irq_en_d = s_wdata[3];
        end
        if (w_clear) begin
            done_d = 1'b0;
        end

        // Completion and start are evaluated after clear so both win over it.
        case (state_q)
            S_IDLE: begin
                abort_pend_d = 1'b0;
                if (w_start) begin
                    aborted_d = 1'b0;
                    if (w_len_zero) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (w_abort) abort_pend_d = 1'b1;
                if (m_ready) begin
                    buf_d   = m_rdata;
                    state_d = S_RD_GAP;
                end
            end
            S_RD_GAP: begin
                if (abort_pend_q || w_abort) begin
                    aborted_d    = 1'b1;
                    abort_pend_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (w_abort) abort_pend_d = 1'b1;
                if (m_ready) begin
                    src_d   = src_q + 32'(ADDR_INC);
                    dst_d   = dst_q + 32'(ADDR_INC);
                    len_d   = len_q - 1'b1;
                    state_d = S_WR_GAP;
                end
            end
            S_WR_GAP: begin
                if (w_len_zero) begin
                    done_d       = 1'b1;
                    abort_pend_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (abort_pend_q || w_abort) begin
                    aborted_d    = 1'b1;
                    abort_pend_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        irq_d = done_d && irq_en_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            buf_q        <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            irq_en_q     <= 1'b0;
            abort_pend_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            buf_q        <= buf_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            irq_en_q     <= irq_en_d;
            abort_pend_q <= abort_pend_d;
            irq_q        <= irq_d;
        end
    end

    // Initiator outputs are decoded from state; SRC/DST/buffer cannot change
    // while a request is outstanding, so they hold stable through wait states.
    always_comb begin
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = 4'b0000;
        case (state_q)
            S_RD: begin
                m_valid = 1'b1;
                m_addr  = src_q;
            end
            S_WR: begin
                m_valid = 1'b1;
                m_addr  = dst_q;
                m_wdata = buf_q;
                m_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        s_ready = s_valid;
        s_rdata = '0;
        if (s_valid) begin
            case (s_addr[3:2])
                c_reg_src: s_rdata = src_q;
                c_reg_dst: s_rdata = dst_q;
                c_reg_len: s_rdata = 32'(len_q);
                default:   s_rdata = {28'd0, irq_en_q, aborted_q, done_q, w_busy};
            endcase
        end
        irq = irq_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dma
// Brief    : Directed self-checking bench for mem_dma with a memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        irq;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_dma #(.LEN_BITS(16), .ADDR_INC(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ready (s_ready),
        .s_rdata (s_rdata),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .irq     (irq)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'h5A00_0000 | 32'(i);
    endfunction

    // ---------------- responder: memory with programmable ready delay -------
    logic [31:0] mem [0:8191];
    int          wcnt;
    int          slow_idx   = -1;
    int          slow_delay = 0;

    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        log_we   [$];
    int          log_len  [$];

    assign m_rdata = mem[m_addr[14:2]];

    always @(posedge clk) begin
        if (reset) begin
            m_ready <= 1'b0;
            wcnt    <= 0;
            for (int i = 0; i < 8192; i++) mem[i] <= pat(i);
        end else if (m_valid && m_ready) begin
            if (m_wstrb == 4'hf) mem[m_addr[14:2]] <= m_wdata;
            m_ready <= 1'b0;
            wcnt    <= 0;
        end else if (m_valid) begin
            if (wcnt >= ((log_addr.size() == slow_idx) ? slow_delay : 0))
                m_ready <= 1'b1;
            else
                wcnt <= wcnt + 1;
        end
    end

    // ---------------- bus monitor ------------------------------------------
    int          stab_err    = 0;
    int          gap_err     = 0;
    int          valid_cycles = 0;
    int          cur_len     = 0;
    logic        pend        = 1'b0;
    logic        gap_chk     = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;

    always @(negedge clk) begin
        if (reset) begin
            pend    = 1'b0;
            gap_chk = 1'b0;
            cur_len = 0;
        end else begin
            if (gap_chk && m_valid) gap_err++;
            gap_chk = 1'b0;
            if (m_valid) begin
                valid_cycles++;
                cur_len++;
                if (pend && (m_addr !== p_addr || m_wdata !== p_wdata || m_wstrb !== p_wstrb))
                    stab_err++;
                if (m_ready) begin
                    log_addr.push_back(m_addr);
                    log_data.push_back(m_wstrb == 4'hf ? m_wdata : m_rdata);
                    log_we.push_back(m_wstrb == 4'hf);
                    log_len.push_back(cur_len);
                    cur_len = 0;
                    pend    = 1'b0;
                    gap_chk = 1'b1;
                end else begin
                    pend    = 1'b1;
                    p_addr  = m_addr;
                    p_wdata = m_wdata;
                    p_wstrb = m_wstrb;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        s_valid = 1'b1; s_addr = a; s_wdata = d; s_wstrb = 4'hf;
        @(negedge clk);
        s_valid = 1'b0; s_wstrb = 4'h0; s_wdata = '0;
    endtask

    task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
        s_valid = 1'b1; s_addr = a; s_wstrb = 4'h0;
        #1 d = s_rdata;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] c;
        c = 32'h1;
        for (int i = 0; i < 2000 && c[0]; i++) begin
            @(negedge clk);
            reg_rd(4'hc, c);
        end
        chk(tag, {31'd0, c[0]}, 32'd0);
    endtask

    task automatic wait_bus(input string tag, input logic [3:0] strb, input logic [31:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #1 hit = m_valid && (m_wstrb == strb) && (m_addr == a);
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ------------------------------------
    initial begin
        logic [31:0] r;
        int          base, vc0;

        reset = 1'b1; s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_s_rdata", s_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reg_rd(4'hc, r); chk("rst_ctrl", r, 32'd0);
        reg_rd(4'h0, r); chk("rst_src", r, 32'd0);
        reg_rd(4'h8, r); chk("rst_len", r, 32'd0);

        // 4-word copy
        reg_wr(4'h0, 32'h0000_4003);
        reg_rd(4'h0, r); chk("src_lsb_forced", r, 32'h0000_4000);
        reg_wr(4'h4, 32'h0000_4100);
        reg_wr(4'h8, 32'hFFFF_0004);
        reg_rd(4'h8, r); chk("len_upper_zero", r, 32'd4);
        base = log_addr.size();
        reg_wr(4'hc, 32'h1);
        wait_idle("copy4_timeout");
        chk("copy4_hs_count", 32'(log_addr.size() - base), 32'd8);
        for (int k = 0; k < 8 && base + k < log_addr.size(); k++) begin
            chk($sformatf("copy4_hs%0d_we", k), {31'd0, log_we[base+k]}, {31'd0, k[0]});
            chk($sformatf("copy4_hs%0d_addr", k), log_addr[base+k],
                (k[0] ? 32'h4100 : 32'h4000) + 32'(4 * (k / 2)));
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("copy4_dst%0d", k), mem[32'h1040 + k], pat(32'h1000 + k));
        chk("copy4_gap", 32'(gap_err), 32'd0);
        chk("copy4_stable", 32'(stab_err), 32'd0);
        reg_rd(4'hc, r); chk("copy4_ctrl", r, 32'h2);
        reg_rd(4'h8, r); chk("copy4_len", r, 32'd0);
        reg_rd(4'h0, r); chk("copy4_src", r, 32'h4010);
        reg_rd(4'h4, r); chk("copy4_dst", r, 32'h4110);

        // LEN=0 start
        reg_wr(4'hc, 32'h2);
        reg_rd(4'hc, r); chk("clear_done", r, 32'h0);
        vc0 = valid_cycles;
        reg_wr(4'hc, 32'h1);
        reg_rd(4'hc, r); chk("len0_done", r, 32'h2);
        repeat (4) @(negedge clk);
        chk("len0_no_bus", 32'(valid_cycles - vc0), 32'd0);

        // start + clear-done in one write: start wins
        reg_wr(4'h8, 32'd1);
        reg_wr(4'hc, 32'h3);
        reg_rd(4'hc, r); chk("start_beats_clear", r, 32'h1);
        wait_idle("start_clear_timeout");

        // wait states on write #2
        reg_wr(4'h0, 32'h4000);
        reg_wr(4'h4, 32'h4100);
        reg_wr(4'h8, 32'd2);
        base       = log_addr.size();
        slow_idx   = base + 3;
        slow_delay = 4;
        reg_wr(4'hc, 32'h1);
        wait_idle("wait_timeout");
        slow_idx = -1;
        chk("wait_hs_count", 32'(log_addr.size() - base), 32'd4);
        if (log_addr.size() >= base + 4) begin
            chk("wait_wr2_addr", log_addr[base+3], 32'h4104);
            chk("wait_wr2_cycles", 32'(log_len[base+3]), 32'd6);
        end
        chk("wait_stable", 32'(stab_err), 32'd0);
        chk("wait_dst1", mem[32'h1041], pat(32'h1001));

        // abort during read of word 3 of 8
        reg_wr(4'h0, 32'h4000);
        reg_wr(4'h4, 32'h4100);
        reg_wr(4'h8, 32'd8);
        base       = log_addr.size();
        slow_idx   = base + 4;
        slow_delay = 3;
        reg_wr(4'hc, 32'h1);
        wait_bus("abort_reach_rd3", 4'h0, 32'h4008);
        reg_wr(4'hc, 32'h4);
        wait_idle("abort_timeout");
        slow_idx = -1;
        chk("abort_hs_count", 32'(log_addr.size() - base), 32'd5);
        chk("abort_last_is_read", {31'd0, log_we[log_we.size()-1]}, 32'd0);
        reg_rd(4'hc, r); chk("abort_ctrl", r, 32'h4);
        reg_rd(4'h8, r); chk("abort_len", r, 32'd6);
        reg_rd(4'h4, r); chk("abort_dst", r, 32'h4108);
        reg_rd(4'h0, r); chk("abort_src", r, 32'h4008);

        // abort in IDLE has no effect
        reg_wr(4'hc, 32'h4);
        reg_rd(4'hc, r); chk("idle_abort", r, 32'h4);

        // writes and start while busy
        reg_wr(4'h0, 32'h4000);
        reg_wr(4'h4, 32'h4100);
        reg_wr(4'h8, 32'd4);
        base = log_addr.size();
        reg_wr(4'hc, 32'h1);
        reg_wr(4'h0, 32'h1234);
        reg_rd(4'h0, r); chk("busy_src_ignored", r, 32'h4000);
        reg_wr(4'hc, 32'h1);
        wait_idle("busy_timeout");
        chk("busy_hs_count", 32'(log_addr.size() - base), 32'd8);
        reg_rd(4'hc, r); chk("busy_ctrl", r, 32'h2);
        reg_rd(4'h0, r); chk("busy_src_final", r, 32'h4010);

        // irq
        reg_wr(4'hc, 32'hA);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        reg_wr(4'h8, 32'd1);
        reg_wr(4'hc, 32'h9);
        chk("irq_low_busy", {31'd0, irq}, 32'd0);
        wait_idle("irq_timeout");
        chk("irq_high", {31'd0, irq}, 32'd1);
        reg_rd(4'hc, r); chk("irq_ctrl", r, 32'hA);
        reg_wr(4'hc, 32'hA);
        chk("irq_after_clear", {31'd0, irq}, 32'd0);

        // reset during WR
        reg_wr(4'h0, 32'h4000);
        reg_wr(4'h4, 32'h4100);
        reg_wr(4'h8, 32'd4);
        reg_wr(4'hc, 32'h9);
        wait_bus("rst_reach_wr", 4'hf, 32'h4100);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wr_m_valid", {31'd0, m_valid}, 32'd0);
        reg_rd(4'h0, r); chk("rst_wr_src", r, 32'd0);
        reg_rd(4'h4, r); chk("rst_wr_dst", r, 32'd0);
        reg_rd(4'h8, r); chk("rst_wr_len", r, 32'd0);
        reg_rd(4'hc, r); chk("rst_wr_ctrl", r, 32'd0);
        chk("rst_wr_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
